avalon_st_rr_arbiter: RTL and testbench

Packet-level round-robin arbiter that merges NUM_SOURCES Avalon-ST source streams onto one Avalon-ST sink. It sits downstream of one avalon_enforcer per source, so every input is already framed SOP…EOP. A grant is locked for a whole packet and is released only on the accepted EOP beat. Each packet costs one arbitration cycle.

---
 rtl/avalon_st_rr_arbiter_if.sv | 24 ++
 rtl/avalon_st_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_avalon_st_rr_arbiter.sv | 533 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_st_rr_arbiter_if.sv
// Shared width helper and the Avalon-ST stream interface used on every arbiter port.
// Empty is sized with log2up_func so a 1-byte bus still carries a 1-bit field.
package avalon_st_pkg;
  function automatic int log2up_func(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int DATA_W  = DATA_WIDTH_IN_BYTES * 8;
  localparam int EMPTY_W = avalon_st_pkg::log2up_func(DATA_WIDTH_IN_BYTES);

  logic [DATA_W-1:0]  data;
  logic [EMPTY_W-1:0] empty;
  logic               sop;
  logic               eop;
  logic               valid;
  logic               rdy;

  modport master (output data, empty, sop, eop, valid, input rdy);
  modport slave  (input data, empty, sop, eop, valid, output rdy);
endinterface

// File: rtl/avalon_st_rr_arbiter.sv
// Packet-level round-robin merge of NUM_SOURCES framed Avalon-ST streams onto one sink.
// A grant is held from SOP until the accepted EOP; each packet costs one arbitration cycle.
module avalon_st_rr_arbiter
  import avalon_st_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int NUM_SOURCES         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  avalon_st_if.slave             src_msg [NUM_SOURCES],
  avalon_st_if.master            merged_msg,
  output logic [NUM_SOURCES-1:0] grant_onehot,
  output logic                   busy,
  output logic [NUM_SOURCES-1:0] stray_beat_indi
);

  localparam int DATA_W  = DATA_WIDTH_IN_BYTES * 8;
  localparam int EMPTY_W = log2up_func(DATA_WIDTH_IN_BYTES);
  localparam int IDX_W   = log2up_func(NUM_SOURCES);

  typedef enum logic {
    IDLE,
    IN_MSG
  } state_t;

  logic [DATA_W-1:0]      src_data  [NUM_SOURCES];
  logic [EMPTY_W-1:0]     src_empty [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] src_valid;
  logic [NUM_SOURCES-1:0] src_sop;
  logic [NUM_SOURCES-1:0] src_eop;
  logic [NUM_SOURCES-1:0] src_rdy;
  logic [NUM_SOURCES-1:0] req;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;

  logic                   out_valid;
  logic                   out_sop;
  logic                   out_eop;
  logic [DATA_W-1:0]      out_data;
  logic [EMPTY_W-1:0]     out_empty;
  logic [NUM_SOURCES-1:0] stray;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    assign src_data[i]    = src_msg[i].data;
    assign src_empty[i]   = src_msg[i].empty;
    assign src_valid[i]   = src_msg[i].valid;
    assign src_sop[i]     = src_msg[i].sop;
    assign src_eop[i]     = src_msg[i].eop;
    assign src_msg[i].rdy = src_rdy[i];
  end

  assign req = src_valid & src_sop;

  // Round-robin pick: the lowest offset from rr_ptr wins, so scan offsets high to low.
  always_comb begin
    logic [IDX_W:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_SOURCES)) begin
        cand = cand - (IDX_W+1)'(NUM_SOURCES);
      end
      if (req[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    src_rdy     = '0;
    stray       = '0;
    out_valid   = 1'b0;
    out_sop     = 1'b0;
    out_eop     = 1'b0;
    out_data    = '0;
    out_empty   = '0;
    case (state_q)
      IDLE: begin
        // Non-SOP beats seen while idle can never start a packet; drain them.
        if (rst) begin
          stray   = src_valid & ~src_sop;
          src_rdy = stray;
        end
        if (pick_vld) begin
          grant_idx_d = pick_idx;
          state_d     = IN_MSG;
        end
      end
      IN_MSG: begin
        out_valid            = src_valid[grant_idx_q];
        src_rdy[grant_idx_q] = merged_msg.rdy;
        if (out_valid) begin
          out_sop   = src_sop[grant_idx_q];
          out_eop   = src_eop[grant_idx_q];
          out_data  = src_data[grant_idx_q];
          out_empty = src_empty[grant_idx_q];
        end
        if (out_valid && src_eop[grant_idx_q] && merged_msg.rdy) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_idx_q == IDX_W'(NUM_SOURCES - 1)) ? '0 : grant_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign merged_msg.valid = out_valid;
  assign merged_msg.sop   = out_sop;
  assign merged_msg.eop   = out_eop;
  assign merged_msg.data  = out_data;
  assign merged_msg.empty = out_empty;

  assign busy            = (state_q == IN_MSG);
  assign grant_onehot    = busy ? (NUM_SOURCES'(1) << grant_idx_q) : '0;
  assign stray_beat_indi = stray;

endmodule

// File: tb/tb_avalon_st_rr_arbiter.sv
// Bench for avalon_st_rr_arbiter: per-source beat queues feed the DUT, directed scenarios
// check fixed expectations and a randomized run is compared against a packet-level model.
module tb_avalon_st_rr_arbiter;
  localparam int DB = 16;
  localparam int NS = 4;
  localparam int DW = DB * 8;
  localparam int EW = 4;
  localparam int QD = 256;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] s_data  [NS];
  logic [EW-1:0] s_empty [NS];
  logic          s_sop   [NS];
  logic          s_eop   [NS];
  logic          s_valid [NS];
  logic          s_rdy   [NS];
  logic          m_rdy;
  logic [NS-1:0] grant_onehot;
  logic [NS-1:0] stray;
  logic          busy;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DB)) src_if [NS] ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DB)) merged_if ();

  for (genvar g = 0; g < NS; g++) begin : g_bind
    assign src_if[g].data  = s_data[g];
    assign src_if[g].empty = s_empty[g];
    assign src_if[g].sop   = s_sop[g];
    assign src_if[g].eop   = s_eop[g];
    assign src_if[g].valid = s_valid[g];
    assign s_rdy[g]        = src_if[g].rdy;
  end
  assign merged_if.rdy = m_rdy;

  avalon_st_rr_arbiter #(.DATA_WIDTH_IN_BYTES(DB), .NUM_SOURCES(NS)) dut (
    .clk             (clk),
    .rst             (rst),
    .src_msg         (src_if),
    .merged_msg      (merged_if),
    .grant_onehot    (grant_onehot),
    .busy            (busy),
    .stray_beat_indi (stray)
  );

  beat_t mem [NS][QD];
  int    head [NS];
  int    tail [NS];
  bit    gap_en;
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic logic [NS-1:0] rdy_vec();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = s_rdy[i];
    return r;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < NS; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic push_beat(input int s, input beat_t b);
    if (tail[s] < QD) begin
      mem[s][tail[s]] = b;
      tail[s]++;
    end
  endtask

  task automatic push_pkt(input int s, input int n, input int emp);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.sop   = (i == 0);
      b.eop   = (i == n - 1);
      b.empty = (i == n - 1) ? EW'(emp) : '0;
      push_beat(s, b);
    end
  endtask

  task automatic push_stray(input int s);
    beat_t b;
    b.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.sop   = 1'b0;
    b.eop   = 1'b0;
    b.empty = '0;
    push_beat(s, b);
  endtask

  // Present each queue head; idle sources show junk with valid low.
  task automatic present();
    for (int i = 0; i < NS; i++) begin
      if (head[i] < tail[i] && (!gap_en || $urandom_range(0, 3) != 0)) begin
        s_valid[i] = 1'b1;
        s_data[i]  = mem[i][head[i]].data;
        s_empty[i] = mem[i][head[i]].empty;
        s_sop[i]   = mem[i][head[i]].sop;
        s_eop[i]   = mem[i][head[i]].eop;
      end else begin
        s_valid[i] = 1'b0;
        s_data[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_empty[i] = EW'($urandom());
        s_sop[i]   = 1'($urandom());
        s_eop[i]   = 1'($urandom());
      end
    end
  endtask

  task automatic tick();
    bit took [NS];
    #2;
    for (int i = 0; i < NS; i++) took[i] = s_valid[i] && s_rdy[i];
    @(posedge clk);
    for (int i = 0; i < NS; i++) if (took[i]) head[i]++;
    #1;
    present();
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    m_rdy  = 1'b0;
    gap_en = 1'b0;
    clear_queues();
    present();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    present();
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    m_rdy  = 1'b1;
    gap_en = 1'b0;
    clear_queues();
    push_stray(1);
    push_pkt(0, 2, 0);
    present();
    repeat (2) begin
      @(posedge clk);
      #2;
      n_checks++;
      if (merged_if.valid !== 1'b0 || merged_if.data !== '0 || busy !== 1'b0 ||
          grant_onehot !== '0 || stray !== '0 || rdy_vec() !== '0) begin
        $display("FAIL reset_outputs: valid=%b busy=%b grant=%b stray=%b rdy=%b, required all 0",
                 merged_if.valid, busy, grant_onehot, stray, rdy_vec());
        n_fail++;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_queues();
    present();
    #1;
    n_checks++;
    if (busy !== 1'b0 || grant_onehot !== '0 || merged_if.valid !== 1'b0) begin
      $display("FAIL reset_release_idle: busy=%b grant=%b valid=%b, required 0 0 0",
               busy, grant_onehot, merged_if.valid);
      n_fail++;
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    m_rdy = 1'b1;
    push_pkt(0, 3, 5);
    present();
    #1;
    n_checks++;
    if (busy !== 1'b0 || merged_if.valid !== 1'b0 || s_rdy[0] !== 1'b0) begin
      $display("FAIL single_arb_cycle: busy=%b valid=%b rdy0=%b, required 0 0 0",
               busy, merged_if.valid, s_rdy[0]);
      n_fail++;
    end
    tick();
    for (int b = 0; b < 3; b++) begin
      logic [EW-1:0] exp_e;
      exp_e = (b == 2) ? EW'(5) : EW'(0);
      #1;
      n_checks++;
      if (busy !== 1'b1 || grant_onehot !== 4'b0001 || merged_if.valid !== 1'b1 ||
          merged_if.sop !== (b == 0) || merged_if.eop !== (b == 2) ||
          merged_if.data !== mem[0][b].data || merged_if.empty !== exp_e || s_rdy[0] !== 1'b1) begin
        $display("FAIL single_beat%0d: grant=%b sop=%b eop=%b empty=%0d data=%h, required grant=0001 empty=%0d data=%h",
                 b, grant_onehot, merged_if.sop, merged_if.eop, merged_if.empty, merged_if.data,
                 exp_e, mem[0][b].data);
        n_fail++;
      end
      tick();
    end
    #1;
    n_checks++;
    if (busy !== 1'b0 || grant_onehot !== '0) begin
      $display("FAIL single_done: busy=%b grant=%b, required 0 0000", busy, grant_onehot);
      n_fail++;
    end
    // rr_ptr should now be 1, so src1 beats src0 in a tie.
    push_pkt(0, 1, 0);
    push_pkt(1, 1, 0);
    present();
    tick();
    #1;
    n_checks++;
    if (grant_onehot !== 4'b0010) begin
      $display("FAIL single_rr_ptr: grant=%b, required 0010", grant_onehot);
      n_fail++;
    end
    tick();
    tick();
    #1;
    n_checks++;
    if (grant_onehot !== 4'b0001) begin
      $display("FAIL single_rr_next: grant=%b, required 0001", grant_onehot);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_g [12] = '{0, 1, 1, 0, 2, 2, 0, 8, 8, 0, 1, 1};
    do_reset();
    m_rdy = 1'b1;
    push_pkt(0, 2, 0);
    push_pkt(1, 2, 0);
    push_pkt(3, 2, 0);
    present();
    for (int c = 0; c < 12; c++) begin
      if (c == 4) begin
        push_pkt(0, 2, 0);
        present();
      end
      #1;
      n_checks++;
      if (grant_onehot !== NS'(exp_g[c]) || busy !== (exp_g[c] != 0) ||
          merged_if.valid !== (exp_g[c] != 0)) begin
        $display("FAIL rr_order c%0d: grant=%b busy=%b valid=%b, required grant=%b",
                 c, grant_onehot, busy, merged_if.valid, NS'(exp_g[c]));
        n_fail++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_rdy = 1'b1;
    push_pkt(2, 3, 0);
    present();
    tick();
    #1;
    n_checks++;
    if (grant_onehot !== 4'b0100 || merged_if.data !== mem[2][0].data || s_rdy[2] !== 1'b1) begin
      $display("FAIL bp_first: grant=%b rdy2=%b data=%h, required 0100 1 %h",
               grant_onehot, s_rdy[2], merged_if.data, mem[2][0].data);
      n_fail++;
    end
    tick();
    m_rdy = 1'b0;
    push_pkt(1, 1, 0);
    present();
    repeat (5) begin
      #1;
      n_checks++;
      if (grant_onehot !== 4'b0100 || merged_if.valid !== 1'b1 || merged_if.data !== mem[2][1].data ||
          s_rdy[2] !== 1'b0 || s_rdy[1] !== 1'b0) begin
        $display("FAIL bp_hold: grant=%b valid=%b rdy2=%b rdy1=%b data=%h, required 0100 1 0 0 %h",
                 grant_onehot, merged_if.valid, s_rdy[2], s_rdy[1], merged_if.data, mem[2][1].data);
        n_fail++;
      end
      tick();
    end
    m_rdy = 1'b1;
    for (int b = 1; b < 3; b++) begin
      #1;
      n_checks++;
      if (grant_onehot !== 4'b0100 || merged_if.data !== mem[2][b].data ||
          merged_if.eop !== (b == 2) || s_rdy[2] !== 1'b1) begin
        $display("FAIL bp_resume%0d: grant=%b eop=%b data=%h, required 0100 %b %h",
                 b, grant_onehot, merged_if.eop, merged_if.data, (b == 2), mem[2][b].data);
        n_fail++;
      end
      tick();
    end
    #1;
    n_checks++;
    if (busy !== 1'b0 || head[2] !== 3) begin
      $display("FAIL bp_count: busy=%b beats_taken=%0d, required 0 3", busy, head[2]);
      n_fail++;
    end
    tick();
    #1;
    n_checks++;
    if (grant_onehot !== 4'b0010 || merged_if.data !== mem[1][0].data) begin
      $display("FAIL bp_next: grant=%b, required 0010", grant_onehot);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_stray();
    do_reset();
    m_rdy = 1'b1;
    push_stray(1);
    push_stray(1);
    present();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (rdy_vec() !== 4'b0010 || stray !== 4'b0010 || merged_if.valid !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL stray_c%0d: rdy=%b stray=%b valid=%b busy=%b, required 0010 0010 0 0",
                 c, rdy_vec(), stray, merged_if.valid, busy);
        n_fail++;
      end
      tick();
    end
    #1;
    n_checks++;
    if (stray !== '0 || head[1] !== 2) begin
      $display("FAIL stray_end: stray=%b dropped=%0d, required 0000 2", stray, head[1]);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int exp_g [8] = '{0, 1, 0, 2, 0, 1, 0, 2};
    do_reset();
    m_rdy = 1'b1;
    push_pkt(0, 1, 3);
    push_pkt(1, 1, 7);
    push_pkt(0, 1, 0);
    push_pkt(1, 1, 1);
    present();
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++;
      if (grant_onehot !== NS'(exp_g[c]) || merged_if.valid !== (exp_g[c] != 0) ||
          (exp_g[c] != 0 && (merged_if.sop !== 1'b1 || merged_if.eop !== 1'b1))) begin
        $display("FAIL b2b_c%0d: grant=%b valid=%b sop=%b eop=%b, required grant=%b",
                 c, grant_onehot, merged_if.valid, merged_if.sop, merged_if.eop, NS'(exp_g[c]));
        n_fail++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_rdy = 1'b1;
    push_pkt(2, 1, 0);
    present();
    tick();
    tick();
    push_pkt(3, 4, 0);
    present();
    tick();
    #1;
    n_checks++;
    if (grant_onehot !== 4'b1000) begin
      $display("FAIL rstmid_grant: grant=%b, required 1000", grant_onehot);
      n_fail++;
    end
    tick();
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (merged_if.valid !== 1'b0 || merged_if.eop !== 1'b0 || merged_if.data !== '0 || busy !== 1'b0 ||
        grant_onehot !== '0 || rdy_vec() !== '0 || stray !== '0) begin
      $display("FAIL rstmid_outputs: valid=%b eop=%b busy=%b grant=%b rdy=%b stray=%b, required all 0",
               merged_if.valid, merged_if.eop, busy, grant_onehot, rdy_vec(), stray);
      n_fail++;
    end
    clear_queues();
    present();
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_pkt(1, 1, 0);
    push_pkt(3, 1, 0);
    present();
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL rstmid_idle: busy=%b, required 0", busy);
      n_fail++;
    end
    tick();
    #1;
    n_checks++;
    if (grant_onehot !== 4'b0010 || merged_if.data !== mem[1][0].data) begin
      $display("FAIL rstmid_regrant: grant=%b, required 0010", grant_onehot);
      n_fail++;
    end
    tick();
    tick();
    #1;
    n_checks++;
    if (grant_onehot !== 4'b1000) begin
      $display("FAIL rstmid_then3: grant=%b, required 1000", grant_onehot);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_random();
    int            owner;
    int            ptr;
    int            total_pkts;
    int            pkts_out;
    int            cyc;
    bit            all_empty;
    logic          exp_valid, exp_sop, exp_eop, exp_busy;
    logic [DW-1:0] exp_data;
    logic [EW-1:0] exp_empty;
    logic [NS-1:0] exp_rdy, exp_stray, exp_grant;
    do_reset();
    gap_en     = 1'b1;
    total_pkts = 0;
    for (int s = 0; s < NS; s++) begin
      int npk;
      npk = $urandom_range(3, 6);
      for (int p = 0; p < npk; p++) begin
        if ($urandom_range(0, 5) == 0) push_stray(s);
        push_pkt(s, $urandom_range(1, 5), $urandom_range(0, 15));
        total_pkts++;
      end
    end
    owner    = -1;
    ptr      = 0;
    pkts_out = 0;
    cyc      = 0;
    present();
    forever begin
      all_empty = 1'b1;
      for (int i = 0; i < NS; i++) if (head[i] < tail[i]) all_empty = 1'b0;
      if (owner < 0 && all_empty) break;
      if (cyc >= 3000) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_timeout: %0d cycles without draining, required drain", cyc);
        break;
      end
      m_rdy = ($urandom_range(0, 3) != 0);
      #1;
      exp_valid = 1'b0; exp_sop = 1'b0; exp_eop = 1'b0; exp_busy = 1'b0;
      exp_data  = '0;   exp_empty = '0;
      exp_rdy   = '0;   exp_stray = '0; exp_grant = '0;
      if (owner < 0) begin
        for (int i = 0; i < NS; i++) begin
          if (s_valid[i] && !s_sop[i]) begin
            exp_rdy[i]   = 1'b1;
            exp_stray[i] = 1'b1;
          end
        end
      end else begin
        exp_busy         = 1'b1;
        exp_grant[owner] = 1'b1;
        exp_rdy[owner]   = m_rdy;
        if (s_valid[owner]) begin
          exp_valid = 1'b1;
          exp_sop   = s_sop[owner];
          exp_eop   = s_eop[owner];
          exp_data  = s_data[owner];
          exp_empty = s_empty[owner];
        end
      end
      n_checks++;
      if (merged_if.valid !== exp_valid || merged_if.sop !== exp_sop || merged_if.eop !== exp_eop ||
          merged_if.data !== exp_data || merged_if.empty !== exp_empty || busy !== exp_busy ||
          grant_onehot !== exp_grant || rdy_vec() !== exp_rdy || stray !== exp_stray) begin
        $display("FAIL rand_c%0d: v/s/e=%b%b%b grant=%b rdy=%b stray=%b data=%h, required %b%b%b %b %b %b %h",
                 cyc, merged_if.valid, merged_if.sop, merged_if.eop, grant_onehot, rdy_vec(), stray,
                 merged_if.data, exp_valid, exp_sop, exp_eop, exp_grant, exp_rdy, exp_stray, exp_data);
        n_fail++;
      end
      if (owner < 0) begin
        for (int k = 0; k < NS; k++) begin
          int j;
          j = (ptr + k) % NS;
          if (s_valid[j] && s_sop[j]) begin
            owner = j;
            break;
          end
        end
      end else if (s_valid[owner] && s_eop[owner] && m_rdy) begin
        pkts_out++;
        ptr   = (owner + 1) % NS;
        owner = -1;
      end
      cyc++;
      tick();
    end
    n_checks++;
    if (pkts_out != total_pkts) begin
      $display("FAIL rand_pkt_count: %0d packets merged, required %0d", pkts_out, total_pkts);
      n_fail++;
    end
    gap_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_stray();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
